// File: rtl/sdram_pkg.sv
// Shared SDRAM controller package: refresh defaults and the debt-counter
// width helper used by the refresh scheduler and its interface.
package sdram_pkg;

  localparam int T_REF_INT_DEF    = 7800;
  localparam int MAX_POSTPONE_DEF = 8;

  // Bits needed to hold a debt value in 0..max_postpone.
  function automatic int debt_width(input int max_postpone);
    return $clog2(max_postpone + 1);
  endfunction

endpackage

// File: rtl/sdram_refresh_scheduler_if.sv
// Refresh request/grant bundle between the refresh scheduler (master) and
// the main command FSM (slave).
//
// Handshake: ref_req is a level that stays high while at least one refresh
// is owed (or, with pull-in, may be issued early). The FSM answers with a
// single-cycle ref_grant pulse for each AUTO REFRESH it actually issues.
// A grant seen while ref_req is low is ignored. ref_urgent means the FSM
// must preempt traffic; ref_overflow is a sticky error flag.
interface sdram_refresh_scheduler_if #(
  parameter int MAX_POSTPONE = sdram_pkg::MAX_POSTPONE_DEF
);
  import sdram_pkg::*;

  localparam int DEBT_W = debt_width(MAX_POSTPONE);

  logic              ref_req;
  logic              ref_urgent;
  logic              ref_grant;
  logic [DEBT_W-1:0] debt_cnt;
  logic              ref_overflow;

  modport master (
    output ref_req,
    output ref_urgent,
    output debt_cnt,
    output ref_overflow,
    input  ref_grant
  );

  modport slave (
    input  ref_req,
    input  ref_urgent,
    input  debt_cnt,
    input  ref_overflow,
    output ref_grant
  );

endinterface

// File: rtl/sdram_interval_timer.sv
// Free-running refresh interval counter. Counts 0..T_REF_INT-1 and emits a
// one-cycle tick on the last count, then wraps. clr holds it at zero.
module sdram_interval_timer #(
  parameter int T_REF_INT = sdram_pkg::T_REF_INT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] LAST_CNT = 32'(T_REF_INT - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // No tick while cleared, so the first tick lands T_REF_INT cycles after clr drops.
  assign tick = !clr && (cnt_q == LAST_CNT);

  // Next count: clear, wrap on tick, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// SDRAM refresh scheduler. Tracks owed AUTO REFRESH commands as a saturating
// debt so the command FSM can postpone refreshes, raises ref_urgent near the
// limit and flags a sticky overflow if a tick arrives with the debt full.
// Optional macro REF_PULL_IN_EN lets the FSM issue up to MAX_PULLIN refreshes
// early while idle; later ticks then repay those instead of adding debt.
module sdram_refresh_scheduler
  import sdram_pkg::*;
#(
  parameter int T_REF_INT     = T_REF_INT_DEF,
  parameter int MAX_POSTPONE  = MAX_POSTPONE_DEF,
  parameter int URGENT_THRESH = 6,
  parameter int MAX_PULLIN    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_init,
  input  logic                       ctrl_idle,
  sdram_refresh_scheduler_if.master  rif
);

  localparam int                DEBT_W     = debt_width(MAX_POSTPONE);
  localparam logic [DEBT_W-1:0] DEBT_MAX   = DEBT_W'(MAX_POSTPONE);
  localparam logic [DEBT_W-1:0] DEBT_URGENT = DEBT_W'(URGENT_THRESH);

  logic              tick;
  logic [DEBT_W-1:0] debt_q;
  logic [DEBT_W-1:0] debt_d;
  logic              ref_overflow_q;
  logic              ref_overflow_d;
  logic              debt_req;
  logic              req;
  logic              grant_ok;

  sdram_interval_timer #(
    .T_REF_INT (T_REF_INT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_init),
    .tick  (tick)
  );

  assign debt_req = (debt_q != '0);

`ifdef REF_PULL_IN_EN
  localparam int              PULL_W   = $clog2(MAX_PULLIN + 1);
  localparam logic [PULL_W-1:0] PULL_MAX = PULL_W'(MAX_PULLIN);

  logic [PULL_W-1:0] pulled_q;
  logic [PULL_W-1:0] pulled_d;
  logic              pull_ok;

  // Early refresh is offered only with no debt, an idle FSM and pull-in room left.
  assign pull_ok = !debt_req && ctrl_idle && (pulled_q < PULL_MAX);
  assign req     = debt_req || pull_ok;
`else
  logic unused_ctrl_idle;
  assign unused_ctrl_idle = ctrl_idle;
  assign req              = debt_req;
`endif

  assign grant_ok = rif.ref_grant && req;

  // Debt / overflow (and pull-in credit) next state; a simultaneous tick and
  // grant cancel out.
  always_comb begin
    debt_d         = debt_q;
    ref_overflow_d = ref_overflow_q;
`ifdef REF_PULL_IN_EN
    pulled_d       = pulled_q;
`endif
    if (in_init) begin
      debt_d = '0;
`ifdef REF_PULL_IN_EN
      pulled_d = '0;
`endif
    end else if (tick && !grant_ok) begin
`ifdef REF_PULL_IN_EN
      if (pulled_q != '0) begin
        pulled_d = pulled_q - PULL_W'(1);
      end else
`endif
      if (debt_q == DEBT_MAX) begin
        ref_overflow_d = 1'b1;
      end else begin
        debt_d = debt_q + DEBT_W'(1);
      end
    end else if (grant_ok && !tick) begin
      if (debt_req) begin
        debt_d = debt_q - DEBT_W'(1);
      end
`ifdef REF_PULL_IN_EN
      else begin
        pulled_d = pulled_q + PULL_W'(1);
      end
`endif
    end
  end

  // State registers; overflow is cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debt_q         <= '0;
      ref_overflow_q <= 1'b0;
`ifdef REF_PULL_IN_EN
      pulled_q       <= '0;
`endif
    end else begin
      debt_q         <= debt_d;
      ref_overflow_q <= ref_overflow_d;
`ifdef REF_PULL_IN_EN
      pulled_q       <= pulled_d;
`endif
    end
  end

  assign rif.ref_req      = req;
  assign rif.ref_urgent   = (debt_q >= DEBT_URGENT);
  assign rif.debt_cnt     = debt_q;
  assign rif.ref_overflow = ref_overflow_q;

endmodule
